// File: rtl/uart_pkg.sv
// Shared UART receive definitions: receiver states, LCR field positions,
// word-length codes and the parity rule.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    localparam int LCR_WLS_LSB = 0;
    localparam int LCR_WLS_MSB = 1;
    localparam int LCR_PEN     = 3;
    localparam int LCR_EPS     = 4;
    localparam int LCR_STICK   = 5;

    typedef enum logic [1:0] {
        WLS_5 = 2'b00,
        WLS_6 = 2'b01,
        WLS_7 = 2'b10,
        WLS_8 = 2'b11
    } wls_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Index of the final data bit: 5..8-bit words end at bit 4..7.
    function automatic logic [2:0] last_bit_idx(input wls_e wls);
        return {1'b1, wls};
    endfunction

    function automatic logic expected_parity(input logic [7:0] data,
                                             input logic       eps,
                                             input logic       stick);
        if (stick) begin
            return ~eps;
        end
        return eps ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-stage synchronizer for the asynchronous serial line plus a
// falling-edge detector used to spot the start bit.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic BCLK,
    input  logic RST,
    input  logic rx_in,
    output logic rxs,
    output logic start_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rxs_prev_q;
    logic                   rxs_prev_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx_in};
        rxs_prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle-line level so leaving reset never looks like a start bit.
    always_ff @(posedge BCLK or posedge RST) begin
        if (RST) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync_q     <= sync_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign start_edge = rxs_prev_q & ~rxs;

endmodule

// File: rtl/receiver_timing_control.sv
// UART receive engine on the 16x baud clock: start detect, mid-bit sampling,
// character assembly into RBR and 16550-style line-status flags.
module receiver_timing_control
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       BCLK,
    input  logic       RST,
    input  logic       rx_in,
    input  logic [7:0] LCR,
    input  logic       rbr_read,
    input  logic       lsr_read,
    output logic [7:0] rbr,
    output logic       data_ready,
    output logic       parity_error,
    output logic       framing_error,
    output logic       break_int,
    output logic       overrun_error,
    output logic       rx_busy
);

    localparam int               CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic rxs;
    logic start_edge;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .BCLK      (BCLK),
        .RST       (RST),
        .rx_in     (rx_in),
        .rxs       (rxs),
        .start_edge(start_edge)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    wls_e             wls_q, wls_d;
    logic             pen_q, pen_d;
    logic             eps_q, eps_d;
    logic             stick_q, stick_d;
    logic             par_pend_q, par_pend_d;
    logic             all_zero_q, all_zero_d;

    logic [7:0]       rbr_q, rbr_d;
    logic             data_ready_q, data_ready_d;
    logic             parity_error_q, parity_error_d;
    logic             framing_error_q, framing_error_d;
    logic             break_int_q, break_int_d;
    logic             overrun_error_q, overrun_error_d;

    logic             tick_last;
    logic [CNT_W-1:0] cnt_step;
    logic             load;
    logic             lcr_unused;

    assign tick_last  = (cnt_q == CNT_LAST);
    assign cnt_step   = tick_last ? '0 : cnt_q + CNT_W'(1);
    assign lcr_unused = ^{LCR[7:6], LCR[2]};

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        wls_d      = wls_q;
        pen_d      = pen_q;
        eps_d      = eps_q;
        stick_d    = stick_q;
        par_pend_d = par_pend_q;
        all_zero_d = all_zero_q;
        load       = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                cnt_d = cnt_step;
                if (cnt_q == CNT_MID) begin
                    if (!rxs) begin
                        // Frame format is frozen here for the rest of the character.
                        state_d    = RX_DATA;
                        cnt_d      = '0;
                        bit_idx_d  = '0;
                        data_d     = '0;
                        wls_d      = wls_e'(LCR[LCR_WLS_MSB:LCR_WLS_LSB]);
                        pen_d      = LCR[LCR_PEN];
                        eps_d      = LCR[LCR_EPS];
                        stick_d    = LCR[LCR_STICK];
                        par_pend_d = 1'b0;
                        all_zero_d = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                cnt_d = cnt_step;
                if (tick_last) begin
                    data_d[bit_idx_q] = rxs;
                    all_zero_d        = all_zero_q & ~rxs;
                    if (bit_idx_q == last_bit_idx(wls_q)) begin
                        state_d = pen_q ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                cnt_d = cnt_step;
                if (tick_last) begin
                    par_pend_d = (rxs != expected_parity(data_q, eps_q, stick_q));
                    all_zero_d = all_zero_q & ~rxs;
                    state_d    = RX_STOP;
                end
            end
            RX_STOP: begin
                cnt_d = cnt_step;
                if (tick_last) begin
                    load    = 1'b1;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // On the load edge rxs is the stop-bit sample; set terms win over lsr_read clears.
    always_comb begin
        rbr_d           = load ? data_q : rbr_q;
        data_ready_d    = (data_ready_q & ~rbr_read) | load;
        overrun_error_d = (overrun_error_q & ~lsr_read) | (load & data_ready_q & ~rbr_read);
        parity_error_d  = (parity_error_q & ~lsr_read) | (load & par_pend_q);
        framing_error_d = (framing_error_q & ~lsr_read) | (load & ~rxs);
        break_int_d     = (break_int_q & ~lsr_read) | (load & all_zero_q & ~rxs);
    end

    always_ff @(posedge BCLK or posedge RST) begin
        if (RST) begin
            state_q         <= RX_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            data_q          <= '0;
            wls_q           <= WLS_5;
            pen_q           <= 1'b0;
            eps_q           <= 1'b0;
            stick_q         <= 1'b0;
            par_pend_q      <= 1'b0;
            all_zero_q      <= 1'b0;
            rbr_q           <= '0;
            data_ready_q    <= 1'b0;
            parity_error_q  <= 1'b0;
            framing_error_q <= 1'b0;
            break_int_q     <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            data_q          <= data_d;
            wls_q           <= wls_d;
            pen_q           <= pen_d;
            eps_q           <= eps_d;
            stick_q         <= stick_d;
            par_pend_q      <= par_pend_d;
            all_zero_q      <= all_zero_d;
            rbr_q           <= rbr_d;
            data_ready_q    <= data_ready_d;
            parity_error_q  <= parity_error_d;
            framing_error_q <= framing_error_d;
            break_int_q     <= break_int_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign rbr           = rbr_q;
    assign data_ready    = data_ready_q;
    assign parity_error  = parity_error_q;
    assign framing_error = framing_error_q;
    assign break_int     = break_int_q;
    assign overrun_error = overrun_error_q;
    assign rx_busy       = (state_q != RX_IDLE);

endmodule

// File: tb/tb_receiver_timing_control.sv
// Bench for receiver_timing_control: frame-level model checked every cycle,
// plus literal expectations for each directed scenario.
`timescale 1ns/1ps
module tb_receiver_timing_control;

    logic       BCLK     = 1'b0;
    logic       RST      = 1'b1;
    logic       rx_in    = 1'b1;
    logic [7:0] LCR      = 8'h03;
    logic       rbr_read = 1'b0;
    logic       lsr_read = 1'b0;

    logic [7:0] rbr;
    logic       data_ready, parity_error, framing_error, break_int, overrun_error, rx_busy;

    always #5 BCLK = ~BCLK;

    receiver_timing_control #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .BCLK         (BCLK),
        .RST          (RST),
        .rx_in        (rx_in),
        .LCR          (LCR),
        .rbr_read     (rbr_read),
        .lsr_read     (lsr_read),
        .rbr          (rbr),
        .data_ready   (data_ready),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .break_int    (break_int),
        .overrun_error(overrun_error),
        .rx_busy      (rx_busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    // A frame is busy on clock edges [from, to); a loading frame updates RBR/LSR on edge 'to'.
    typedef struct {
        int         from;
        int         to;
        bit         load;
        logic [7:0] d;
        bit         pe;
        bit         fe;
        bit         bi;
    } frame_t;

    frame_t     fq[$];
    logic [7:0] m_rbr  = 8'h00;
    bit         m_dr   = 1'b0;
    bit         m_pe   = 1'b0;
    bit         m_fe   = 1'b0;
    bit         m_bi   = 1'b0;
    bit         m_oe   = 1'b0;
    bit         m_busy = 1'b0;

    // Falling rx_in driven after edge c is seen as a start on edge c+3 (two sync flops, then detect).
    function automatic void expect_frame(input int c, input logic [7:0] lcr, input logic [7:0] d,
                                         input bit par, input bit stop);
        frame_t     f;
        int         n;
        int         p;
        int         ones;
        logic [7:0] md;
        bit         exp_par;
        n    = 5 + int'(lcr[1:0]);
        p    = int'(lcr[3]);
        md   = d & 8'((1 << n) - 1);
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(md[i]);
        if (lcr[5])      exp_par = !lcr[4];
        else if (lcr[4]) exp_par = (ones % 2) == 1;
        else             exp_par = (ones % 2) == 0;
        f.from = c + 3;
        f.to   = c + 3 + 8 + 16 * (n + p + 1);
        f.load = 1'b1;
        f.d    = md;
        f.pe   = (p == 1) && (par != exp_par);
        f.fe   = !stop;
        f.bi   = (md == 8'h00) && !((p == 1) && par) && !stop;
        fq.push_back(f);
    endfunction

    always @(posedge BCLK or posedge RST) begin
        bit     ld;
        frame_t f;
        if (RST) begin
            m_rbr  = 8'h00;
            m_dr   = 1'b0;
            m_pe   = 1'b0;
            m_fe   = 1'b0;
            m_bi   = 1'b0;
            m_oe   = 1'b0;
            m_busy = 1'b0;
            fq.delete();
        end else begin
            cyc++;
            ld = 1'b0;
            if (fq.size() > 0 && fq[0].load && fq[0].to == cyc) begin
                ld = 1'b1;
                f  = fq[0];
            end
            if (lsr_read) begin
                m_pe = 1'b0;
                m_fe = 1'b0;
                m_bi = 1'b0;
                m_oe = 1'b0;
            end
            if (ld) begin
                if (m_dr && !rbr_read) m_oe = 1'b1;
                if (f.pe) m_pe = 1'b1;
                if (f.fe) m_fe = 1'b1;
                if (f.bi) m_bi = 1'b1;
                m_rbr = f.d;
                m_dr  = 1'b1;
            end else if (rbr_read) begin
                m_dr = 1'b0;
            end
            while (fq.size() > 0 && fq[0].to <= cyc) void'(fq.pop_front());
            m_busy = (fq.size() > 0) && (cyc >= fq[0].from);
        end
    end

    always @(negedge BCLK) begin
        if (!RST) begin
            check("outputs {rbr,dr,pe,fe,bi,oe,busy}",
                  32'({rbr, data_ready, parity_error, framing_error, break_int, overrun_error, rx_busy}),
                  32'({m_rbr, m_dr, m_pe, m_fe, m_bi, m_oe, m_busy}));
        end
    end

    // ---------------- stimulus ----------------
    int last_c   = 0;
    int obs_load = -1;

    task automatic send_frame(input logic [7:0] lcr, input logic [7:0] d, input bit par,
                              input bit stop, input bit rd_at_load, input int abort_after);
        int          n;
        int          p;
        int          load_at;
        bit          prev_dr;
        logic [11:0] bits;
        @(negedge BCLK);
        LCR  = lcr;
        n    = 5 + int'(lcr[1:0]);
        p    = int'(lcr[3]);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < n; i++) bits[1 + i] = d[i];
        if (p == 1) bits[1 + n] = par;
        bits[1 + n + p] = stop;
        last_c = cyc;
        expect_frame(cyc, lcr, d, par, stop);
        load_at  = cyc + 11 + 16 * (n + p + 1);
        obs_load = -1;
        prev_dr  = data_ready;
        for (int i = 0; i < 16 * (n + p + 2); i++) begin
            if (abort_after > 0 && i == abort_after) break;
            if (obs_load < 0 && data_ready && !prev_dr) obs_load = cyc;
            prev_dr  = data_ready;
            rx_in    = bits[i / 16];
            rbr_read = rd_at_load && (cyc == load_at - 1);
            @(negedge BCLK);
        end
        rx_in    = 1'b1;
        rbr_read = 1'b0;
        if (abort_after == 0) repeat (24) @(negedge BCLK);
    endtask

    task automatic glitch(input int len);
        frame_t f;
        @(negedge BCLK);
        f = '{from: cyc + 3, to: cyc + 11, load: 1'b0, d: 8'h00, pe: 1'b0, fe: 1'b0, bi: 1'b0};
        fq.push_back(f);
        rx_in = 1'b0;
        repeat (len) @(negedge BCLK);
        rx_in = 1'b1;
        repeat (24) @(negedge BCLK);
    endtask

    task automatic hold_low(input int len);
        @(negedge BCLK);
        LCR = 8'h03;
        expect_frame(cyc, 8'h03, 8'h00, 1'b0, 1'b0);
        rx_in = 1'b0;
        repeat (len) @(negedge BCLK);
        rx_in = 1'b1;
        repeat (24) @(negedge BCLK);
    endtask

    task automatic clear_status();
        @(negedge BCLK);
        rbr_read = 1'b1;
        lsr_read = 1'b1;
        @(negedge BCLK);
        rbr_read = 1'b0;
        lsr_read = 1'b0;
    endtask

    task automatic pulse_lsr();
        @(negedge BCLK);
        lsr_read = 1'b1;
        @(negedge BCLK);
        lsr_read = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge BCLK);
        check("reset rbr/flags/busy",
              32'({rbr, data_ready, parity_error, framing_error, break_int, overrun_error, rx_busy}), 32'h0);
        RST = 1'b0;
        repeat (4) @(negedge BCLK);

        // 8N1 0xA5: load 155 edges after the falling-edge drive (3 to detect + 152).
        send_frame(8'h03, 8'hA5, 1'b0, 1'b1, 1'b0, 0);
        check("8N1 rbr", 32'(rbr), 32'hA5);
        check("8N1 data_ready", 32'(data_ready), 32'h1);
        check("8N1 error flags", 32'({parity_error, framing_error, break_int, overrun_error}), 32'h0);
        check("8N1 load latency", 32'(obs_load - last_c), 32'd155);
        clear_status();

        // 7E1 0x35: four ones, so even parity expects a 0 parity bit.
        send_frame(8'h1A, 8'h35, 1'b1, 1'b1, 1'b0, 0);
        check("7E1 bad parity rbr", 32'(rbr), 32'h35);
        check("7E1 bad parity flag", 32'(parity_error), 32'h1);
        pulse_lsr();
        @(negedge BCLK);
        check("lsr_read clears parity", 32'(parity_error), 32'h0);
        clear_status();
        send_frame(8'h1A, 8'h35, 1'b0, 1'b1, 1'b0, 0);
        check("7E1 good parity flag", 32'(parity_error), 32'h0);
        check("7E1 good parity rbr", 32'(rbr), 32'h35);
        clear_status();

        // Short low glitch is a false start; state untouched.
        glitch(4);
        check("glitch rbr kept", 32'(rbr), 32'h35);
        check("glitch no data_ready", 32'(data_ready), 32'h0);
        check("glitch idle", 32'(rx_busy), 32'h0);
        send_frame(8'h00, 8'h1F, 1'b0, 1'b1, 1'b0, 0);
        check("5N1 rbr", 32'(rbr), 32'h1F);
        clear_status();

        // Line low for two frame times: one break load, no retrigger.
        hold_low(320);
        check("break flags {fe,bi}", 32'({framing_error, break_int}), 32'h3);
        check("break rbr", 32'(rbr), 32'h00);
        check("break single load", 32'(overrun_error), 32'h0);
        clear_status();

        // Overrun without a read, then with a read on the second load edge.
        send_frame(8'h03, 8'h11, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h03, 8'h22, 1'b0, 1'b1, 1'b0, 0);
        check("overrun flag", 32'(overrun_error), 32'h1);
        check("overrun rbr", 32'(rbr), 32'h22);
        clear_status();
        send_frame(8'h03, 8'h11, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h03, 8'h22, 1'b0, 1'b1, 1'b1, 0);
        check("read at load no overrun", 32'(overrun_error), 32'h0);
        check("read at load data_ready", 32'(data_ready), 32'h1);
        clear_status();

        // Reset in the middle of the data bits of 0xFF.
        send_frame(8'h03, 8'hFF, 1'b0, 1'b1, 1'b0, 64);
        check("mid-frame busy", 32'(rx_busy), 32'h1);
        #2 RST = 1'b1;
        #1;
        check("mid-frame reset outputs",
              32'({rbr, data_ready, parity_error, framing_error, break_int, overrun_error, rx_busy}), 32'h0);
        repeat (3) @(negedge BCLK);
        RST = 1'b0;
        repeat (4) @(negedge BCLK);
        send_frame(8'h03, 8'h5A, 1'b0, 1'b1, 1'b0, 0);
        check("post-reset rbr", 32'(rbr), 32'h5A);
        check("post-reset flags", 32'({parity_error, framing_error, break_int, overrun_error}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
